clock_counter_reader: RTL and testbench

Memory-mapped reader for the counters and mode flags produced by the clock subsystem. It lets the core read 64-bit `core_clock_ticks` and `miliseconds` coherently over a 32-bit bus, and it reports the manual and slow clock modes. It also provides a millisecond compare interrupt. It sits on the core's peripheral bus in the `core_clock` domain.

---
 rtl/clock_counter_reader.sv | 164 ++++++++++++++++
 tb/tb_clock_counter_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_counter_reader.sv
// Coherent 32-bit bus reader for the 64-bit tick and millisecond counters, the clock mode flags
// and an optional millisecond compare interrupt.
// Build option: define CLOCK_READER_IRQ_EN to include CMP_LO/CMP_HI/CONTROL, the pending flag and
// timer_irq. Without it those registers read 0, ignore writes, and timer_irq is tied low.
module clock_counter_reader #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  core_clock,
  input  logic                  reset_n,
  input  logic [63:0]           core_clock_ticks,
  input  logic [63:0]           miliseconds,
  input  logic                  clock_manual_mode,
  input  logic                  clock_slow_mode,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic                  timer_irq
);

  localparam logic [2:0] RegTicksLo = 3'd0;
  localparam logic [2:0] RegTicksHi = 3'd1;
  localparam logic [2:0] RegMsLo    = 3'd2;
  localparam logic [2:0] RegMsHi    = 3'd3;
  localparam logic [2:0] RegCmpLo   = 3'd4;
  localparam logic [2:0] RegCmpHi   = 3'd5;
  localparam logic [2:0] RegStatus  = 3'd6;
  localparam logic [2:0] RegControl = 3'd7;

  logic [2:0] reg_idx;
  assign reg_idx = address[4:2];

  // Byte-lane bits and, when the compare block is absent, the write path are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{address[1:0], write_data, write_enable};

  // ---------------------------------------------------------------------------------------------
  // Millisecond capture: the counter comes from another clock domain, so only a value seen
  // identically in two consecutive samples is accepted.
  // ---------------------------------------------------------------------------------------------
  logic [63:0] ms_s1_q, ms_s2_q, ms_stable_q, ms_stable_d;

  // Accept the older sample only when both samples agree; otherwise keep the last good value.
  always_comb begin
    ms_stable_d = ms_stable_q;
    if (ms_s1_q == ms_s2_q) ms_stable_d = ms_s2_q;
  end

  // Sampling chain and stable value.
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      ms_s1_q     <= '0;
      ms_s2_q     <= '0;
      ms_stable_q <= '0;
    end else begin
      ms_s1_q     <= miliseconds;
      ms_s2_q     <= ms_s1_q;
      ms_stable_q <= ms_stable_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Compare / interrupt block
  // ---------------------------------------------------------------------------------------------
  logic [63:0] cmp_rd;
  logic        irq_pending_rd;
  logic        irq_enable_rd;

`ifdef CLOCK_READER_IRQ_EN
  logic [63:0] cmp_q, cmp_d;
  logic        irq_enable_q, irq_enable_d;
  logic        irq_pending_q, irq_pending_d;
  logic        timer_irq_q;

  // Register writes; a compare hit is applied last so it overrides a clear in the same cycle.
  always_comb begin
    cmp_d         = cmp_q;
    irq_enable_d  = irq_enable_q;
    irq_pending_d = irq_pending_q;
    if (write_enable) begin
      case (reg_idx)
        RegCmpLo:   cmp_d[31:0]  = write_data;
        RegCmpHi:   cmp_d[63:32] = write_data;
        RegStatus:  if (write_data[2]) irq_pending_d = 1'b0;
        RegControl: irq_enable_d = write_data[0];
        default:    ;
      endcase
    end
    if (ms_stable_q >= cmp_q) irq_pending_d = 1'b1;
  end

  // Compare state and registered interrupt output.
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      cmp_q         <= '1;
      irq_enable_q  <= 1'b0;
      irq_pending_q <= 1'b0;
      timer_irq_q   <= 1'b0;
    end else begin
      cmp_q         <= cmp_d;
      irq_enable_q  <= irq_enable_d;
      irq_pending_q <= irq_pending_d;
      timer_irq_q   <= irq_pending_q & irq_enable_q;
    end
  end

  assign cmp_rd         = cmp_q;
  assign irq_pending_rd = irq_pending_q;
  assign irq_enable_rd  = irq_enable_q;
  assign timer_irq      = timer_irq_q;
`else
  assign cmp_rd         = '0;
  assign irq_pending_rd = 1'b0;
  assign irq_enable_rd  = 1'b0;
  assign timer_irq      = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  logic [31:0] rdata_mux;
  logic [31:0] read_data_q;
  logic        read_valid_q;
  logic [31:0] ticks_shadow_q, ms_shadow_q;

  // Select the read value from pre-edge state, so a simultaneous write is not yet visible.
  always_comb begin
    rdata_mux = '0;
    case (reg_idx)
      RegTicksLo: rdata_mux = core_clock_ticks[31:0];
      RegTicksHi: rdata_mux = ticks_shadow_q;
      RegMsLo:    rdata_mux = ms_stable_q[31:0];
      RegMsHi:    rdata_mux = ms_shadow_q;
      RegCmpLo:   rdata_mux = cmp_rd[31:0];
      RegCmpHi:   rdata_mux = cmp_rd[63:32];
      RegStatus:  rdata_mux = {29'd0, irq_pending_rd, clock_slow_mode, clock_manual_mode};
      RegControl: rdata_mux = {31'd0, irq_enable_rd};
      default:    rdata_mux = '0;
    endcase
  end

  // Registered read response; a LO read freezes the matching HI half for a coherent 64-bit read.
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      ticks_shadow_q <= '0;
      ms_shadow_q    <= '0;
    end else begin
      read_valid_q <= read_enable;
      if (read_enable) begin
        read_data_q <= rdata_mux;
        if (reg_idx == RegTicksLo) ticks_shadow_q <= core_clock_ticks[63:32];
        if (reg_idx == RegMsLo)    ms_shadow_q    <= ms_stable_q[63:32];
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_clock_counter_reader.sv
// Scoreboard bench for clock_counter_reader: a reference model predicts every read response and
// the interrupt level; a monitor compares them against the DUT on the falling edge.
`timescale 1ns/1ps
module tb_clock_counter_reader;

`ifdef CLOCK_READER_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic        core_clock = 1'b0;
  logic        reset_n    = 1'b0;
  logic [63:0] core_clock_ticks;
  logic [63:0] miliseconds;
  logic        clock_manual_mode, clock_slow_mode;
  logic [4:0]  address;
  logic        read_enable, write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic        timer_irq;

  always #5 core_clock = ~core_clock;

  clock_counter_reader #(.ADDR_WIDTH(5)) dut (
    .core_clock        (core_clock),
    .reset_n           (reset_n),
    .core_clock_ticks  (core_clock_ticks),
    .miliseconds       (miliseconds),
    .clock_manual_mode (clock_manual_mode),
    .clock_slow_mode   (clock_slow_mode),
    .address           (address),
    .read_enable       (read_enable),
    .write_enable      (write_enable),
    .write_data        (write_data),
    .read_data         (read_data),
    .read_valid        (read_valid),
    .timer_irq         (timer_irq)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Reference model (register-file view of the block, stepped once per rising edge)
  // ---------------------------------------------------------------------------------------------
  logic [63:0] samp_new, samp_old;   // two most recent samples of the millisecond input
  logic [63:0] m_stable, m_cmp;
  logic [31:0] m_tick_hi, m_ms_hi;
  logic        m_en, m_pend, m_timer, m_rd_last;
  logic        hit, nxt_pend, nxt_timer;
  logic [2:0]  idx;

  function automatic logic [31:0] model_read(input logic [2:0] i);
    case (i)
      3'd0:    return core_clock_ticks[31:0];
      3'd1:    return m_tick_hi;
      3'd2:    return m_stable[31:0];
      3'd3:    return m_ms_hi;
      3'd4:    return IrqEn ? m_cmp[31:0] : 32'd0;
      3'd5:    return IrqEn ? m_cmp[63:32] : 32'd0;
      3'd6:    return {29'd0, IrqEn & m_pend, clock_slow_mode, clock_manual_mode};
      default: return {31'd0, IrqEn & m_en};
    endcase
  endfunction

  always @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      samp_new = '0; samp_old = '0; m_stable = '0; m_cmp = '1;
      m_tick_hi = '0; m_ms_hi = '0; m_en = 1'b0; m_pend = 1'b0; m_timer = 1'b0;
      m_rd_last = 1'b0;
      exp_q.delete();
    end else begin
      idx       = address[4:2];
      hit       = IrqEn && (m_stable >= m_cmp);
      nxt_timer = IrqEn & m_pend & m_en;
      nxt_pend  = m_pend;
      if (read_enable) begin
        exp_q.push_back(model_read(idx));
        if (idx == 3'd0) m_tick_hi = core_clock_ticks[63:32];
        if (idx == 3'd2) m_ms_hi = m_stable[63:32];
      end
      m_rd_last = read_enable;
      if (write_enable && IrqEn) begin
        case (idx)
          3'd4:    m_cmp[31:0] = write_data;
          3'd5:    m_cmp[63:32] = write_data;
          3'd6:    if (write_data[2]) nxt_pend = 1'b0;
          3'd7:    m_en = write_data[0];
          default: ;
        endcase
      end
      if (hit) nxt_pend = 1'b1;
      // A value is accepted once it has been seen in two consecutive samples.
      if (samp_new == samp_old) m_stable = samp_old;
      samp_old = samp_new;
      samp_new = miliseconds;
      m_pend   = nxt_pend;
      m_timer  = nxt_timer;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------------------------
  logic [31:0] mon_last = '0;
  logic [31:0] e;

  always @(negedge core_clock) begin
    if (!reset_n) mon_last = '0;
    check("read_valid", {63'd0, read_valid}, {63'd0, m_rd_last});
    check("timer_irq", {63'd0, timer_irq}, {63'd0, m_timer});
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", {32'd0, read_data}, 64'hDEAD_0000_0000_0000);
      end else begin
        e = exp_q.pop_front();
        check("read_data", {32'd0, read_data}, {32'd0, e});
        mon_last = e;
      end
    end else begin
      check("read_data_hold", {32'd0, read_data}, {32'd0, mon_last});
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus: inputs change 2 ns after the rising edge
  // ---------------------------------------------------------------------------------------------
  task automatic cyc();
    @(posedge core_clock);
    #2;
  endtask

  task automatic op(input logic re, input logic we, input logic [2:0] i, input logic [31:0] d);
    address      = {i, 2'b00};
    read_enable  = re;
    write_enable = we;
    write_data   = d;
    cyc();
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [2:0] i);
    op(1'b1, 1'b0, i, 32'd0);
  endtask

  task automatic wr(input logic [2:0] i, input logic [31:0] d);
    op(1'b0, 1'b1, i, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [63:0] ms_cur;
  int          sel;

  initial begin
    core_clock_ticks = '0; miliseconds = '0; clock_manual_mode = 1'b0; clock_slow_mode = 1'b0;
    address = '0; read_enable = 1'b0; write_enable = 1'b0; write_data = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    // Reset state of HI shadows and compare register.
    rd(3'd1); rd(3'd3); rd(3'd5); rd(3'd6); rd(3'd7);

    // Coherent tick read across a carry.
    core_clock_ticks = 64'h0000_0001_FFFF_FFFF;
    rd(3'd0);
    core_clock_ticks = 64'h0000_0002_0000_0000;
    rd(3'd1);

    // Millisecond input toggling every cycle must not be captured.
    for (int i = 0; i < 10; i++) begin
      miliseconds = (i % 2 == 0) ? 64'd77 : 64'd78;
      cyc();
    end
    rd(3'd2);
    miliseconds = 64'd1234;
    repeat (3) cyc();
    rd(3'd2); rd(3'd3);

    // Interrupt ramp, then a clear while still above the compare value.
    wr(3'd4, 32'd100); wr(3'd5, 32'd0); wr(3'd7, 32'd1);
    rd(3'd4); rd(3'd5); rd(3'd7);
    for (int v = 98; v <= 101; v++) begin
      miliseconds = 64'(v);
      repeat (4) cyc();
    end
    wr(3'd6, 32'h4);
    rd(3'd6);
    wr(3'd5, 32'hFFFF_FFFF); wr(3'd6, 32'h4);
    cyc(); cyc();
    rd(3'd6);

    // Status flags and read-only registers.
    clock_manual_mode = 1'b1; clock_slow_mode = 1'b0;
    rd(3'd6);
    wr(3'd0, 32'h1111_1111); wr(3'd1, 32'h2222_2222); wr(3'd2, 32'h3333_3333);
    wr(3'd3, 32'h4444_4444);
    rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3);

    // Simultaneous read and write returns the old value.
    op(1'b1, 1'b1, 3'd4, 32'd55);
    rd(3'd4);

    // Compare writes are ignored without the compare block; timer stays low with ms >= 5.
    wr(3'd4, 32'd5); wr(3'd5, 32'd0); wr(3'd7, 32'd1);
    rd(3'd4); rd(3'd7);
    repeat (4) cyc();

    // Reset arriving with a read strobe cancels the read.
    address = {3'd6, 2'b00}; read_enable = 1'b1; reset_n = 1'b0;
    cyc();
    read_enable = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    rd(3'd5); rd(3'd1);

    // Randomised traffic.
    ms_cur = 64'd0;
    for (int n = 0; n < 500; n++) begin
      core_clock_ticks = core_clock_ticks + 64'($urandom_range(1, 1 << 20)) * 64'd4096;
      if ($urandom_range(0, 1) == 0) ms_cur = ms_cur + 64'($urandom_range(0, 20));
      if ($urandom_range(0, 60) == 0) ms_cur = {32'($urandom_range(0, 2)), $urandom};
      miliseconds       = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : ms_cur;
      clock_manual_mode = 1'($urandom_range(0, 1));
      clock_slow_mode   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        rd(3'($urandom_range(0, 7)));
      end else if (sel < 7) begin
        idx = 3'($urandom_range(0, 7));
        if (idx == 3'd4) wr(idx, $urandom_range(0, 3000));
        else if (idx == 3'd5) wr(idx, ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'd0);
        else wr(idx, $urandom);
      end else if (sel == 7) begin
        op(1'b1, 1'b1, 3'($urandom_range(4, 7)), $urandom);
      end else begin
        cyc();
      end
    end

    repeat (3) cyc();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
